// File: rtl/timer_sched_if.sv
// rtl/timer_sched_if.sv - requester and timer-control bundle for timer_sched (TIMER_SCHED_WDOG_EN adds wdog_err)
interface timer_sched_if #(
   parameter int NREQ   = 4,
   parameter int DWIDTH = 8
);
   logic [NREQ-1:0]        req;
   logic [NREQ*DWIDTH-1:0] period;
   logic [NREQ-1:0]        grant;
   logic [NREQ-1:0]        done;
   logic                   busy;
   logic                   tmr_enable;
   logic                   tmr_load;
   logic [DWIDTH-1:0]      tmr_load_val;
   logic                   tmr_flag;
`ifdef TIMER_SCHED_WDOG_EN
   logic                   wdog_err;
`endif

   modport master (
      input  req, period, tmr_flag,
`ifdef TIMER_SCHED_WDOG_EN
      output wdog_err,
`endif
      output grant, done, busy, tmr_enable, tmr_load, tmr_load_val
   );

   modport slave (
      output req, period, tmr_flag,
`ifdef TIMER_SCHED_WDOG_EN
      input  wdog_err,
`endif
      input  grant, done, busy, tmr_enable, tmr_load, tmr_load_val
   );
endinterface

// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - round-robin sharing of one enable/load/flag timer among NREQ requesters
// TIMER_SCHED_WDOG_EN adds a RUN watchdog that aborts a grant whose timer never flags.
module timer_sched #(
   parameter int NREQ   = 4,
   parameter int DWIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   timer_sched_if.master bus
);
   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IW-1:0]     owner;
   logic [IW-1:0]     owner_inc;
   logic [IW-1:0]     rr_ptr;
   logic [IW-1:0]     pick_idx;
   logic [IW-1:0]     scan_idx;
   logic              pick_found;
   logic              owner_req;
   logic [DWIDTH-1:0] per_q;
   logic [DWIDTH-1:0] per_arr [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign per_arr[gi] = bus.period[gi*DWIDTH +: DWIDTH];
   end

   assign owner_req = bus.req[owner];
   assign owner_inc = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);

   // First pending requester at or after rr_ptr, wrapping past NREQ-1.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = IW'((int'(rr_ptr) + k) % NREQ);
         if (!pick_found && bus.req[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

`ifdef TIMER_SCHED_WDOG_EN
   localparam int CW = DWIDTH + 2;

   logic [CW-1:0] wd_cnt;
   logic [CW-1:0] wd_limit;
   logic          wd_trip;
   logic          wdog_q;

   // wd_cnt holds completed RUN cycles, so the trip lands on cycle 2*per_q+4.
   assign wd_limit = {1'b0, per_q, 1'b0} + CW'(4);
   assign wd_trip  = (state == S_RUN) && !bus.tmr_flag && (wd_cnt == wd_limit - CW'(1));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (pick_found) begin
               state_nxt = (per_arr[pick_idx] == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: state_nxt = S_RUN;
         S_RUN: begin
            // Expiry beats a same-cycle cancel so the owner still sees done.
            if (bus.tmr_flag) begin
               state_nxt = S_DONE;
            end else if (!owner_req) begin
               state_nxt = S_IDLE;
`ifdef TIMER_SCHED_WDOG_EN
            end else if (wd_trip) begin
               state_nxt = S_IDLE;
`endif
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner  <= '0;
         per_q  <= '0;
         rr_ptr <= '0;
      end else begin
         if (state == S_IDLE && pick_found) begin
            owner <= pick_idx;
            per_q <= per_arr[pick_idx];
         end
         // Completion, cancel and abort all move priority past the owner.
         if (state == S_DONE || (state == S_RUN && state_nxt == S_IDLE)) begin
            rr_ptr <= owner_inc;
         end
      end
   end

`ifdef TIMER_SCHED_WDOG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
         wdog_q <= 1'b0;
      end else begin
         if (state_nxt == S_LOAD) begin
            wd_cnt <= '0;
         end else if (state == S_RUN) begin
            wd_cnt <= wd_cnt + CW'(1);
         end
         wdog_q <= (state == S_RUN) && (state_nxt == S_IDLE) && owner_req;
      end
   end

   assign bus.wdog_err = wdog_q;
`endif

   always_comb begin
      bus.grant = '0;
      bus.done  = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.grant[i] = (state != S_IDLE) && (owner == IW'(i));
         bus.done[i]  = (state == S_DONE) && (owner == IW'(i));
      end
      bus.busy         = (state != S_IDLE);
      bus.tmr_enable   = (state == S_RUN);
      bus.tmr_load     = (state == S_LOAD);
      bus.tmr_load_val = (state == S_LOAD) ? per_q : '0;
   end
endmodule

// File: tb/tb_timer_sched.sv
// tb/tb_timer_sched.sv - directed scoreboard bench for timer_sched with a behavioural shared timer
module tb_timer_sched;
   localparam int NREQ   = 4;
   localparam int DWIDTH = 8;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   timer_sched_if #(.NREQ(NREQ), .DWIDTH(DWIDTH)) bus ();

   timer_sched #(.NREQ(NREQ), .DWIDTH(DWIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Timer raises flag during its period-th enabled cycle after a load.
   logic              tmr_auto;
   logic              tmr_manual;
   logic [DWIDTH-1:0] tm_val = '0;
   int                tm_en_cnt = 0;

   always_ff @(posedge clk) begin
      if (bus.tmr_load) begin
         tm_val    <= bus.tmr_load_val;
         tm_en_cnt <= 0;
      end else if (bus.tmr_enable) begin
         tm_en_cnt <= tm_en_cnt + 1;
      end
   end

   assign bus.tmr_flag = tmr_auto ? (bus.tmr_enable && (tm_en_cnt == int'(tm_val) - 1)) : tmr_manual;

   logic [NREQ-1:0] exp_q [$];

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_period(input int idx, input logic [DWIDTH-1:0] val);
      bus.period[idx*DWIDTH +: DWIDTH] = val;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_done(input int budget, output logic [NREQ-1:0] seen,
                            output int en_cyc, output logic [NREQ-1:0] grant_or);
      en_cyc   = 0;
      grant_or = '0;
      for (int i = 0; i < budget; i++) begin
         if (bus.done != '0) break;
         if (bus.tmr_enable) en_cyc++;
         grant_or |= bus.grant;
         step();
      end
      seen = bus.done;
   endtask

   initial begin
      #50000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [NREQ-1:0] seen;
      logic [NREQ-1:0] gor;
      logic [NREQ-1:0] exp;
      int              en;

      rst        = 1'b1;
      bus.req    = '0;
      bus.period = '0;
      tmr_auto   = 1'b1;
      tmr_manual = 1'b0;
      repeat (2) step();
      check("rst_grant",    32'(bus.grant),        32'd0);
      check("rst_done",     32'(bus.done),         32'd0);
      check("rst_busy",     32'(bus.busy),         32'd0);
      check("rst_enable",   32'(bus.tmr_enable),   32'd0);
      check("rst_load",     32'(bus.tmr_load),     32'd0);
      check("rst_load_val", 32'(bus.tmr_load_val), 32'd0);
      rst = 1'b0;

      // Single requester, period 10.
      set_period(0, 8'd10);
      bus.req = 4'b0001;
      exp_q.push_back(4'b0001);
      step();
      check("single_load",     32'(bus.tmr_load),     32'd1);
      check("single_load_val", 32'(bus.tmr_load_val), 32'd10);
      check("single_grant",    32'(bus.grant),        32'h1);
      check("single_en_off",   32'(bus.tmr_enable),   32'd0);
      step();
      check("single_enable",   32'(bus.tmr_enable),   32'd1);
      check("single_load_off", 32'(bus.tmr_load),     32'd0);
      wait_done(40, seen, en, gor);
      exp = exp_q.pop_front();
      check("single_done",       32'(seen),      32'(exp));
      check("single_run_cycles", 32'(en),        32'd10);
      check("single_grant_run",  32'(gor),       32'(exp));
      check("single_grant_done", 32'(bus.grant), 32'(exp));
      bus.req = '0;
      step();
      check("single_done_pulse", 32'(bus.done), 32'd0);
      check("single_idle",       32'(bus.busy), 32'd0);

      // Round robin among 0,1,3 from a fresh pointer.
      pulse_reset();
      for (int i = 0; i < NREQ; i++) set_period(i, 8'd3);
      bus.req = 4'b1011;
      repeat (2) begin
         exp_q.push_back(4'b0001);
         exp_q.push_back(4'b0010);
         exp_q.push_back(4'b1000);
      end
      for (int n = 0; n < 6; n++) begin
         wait_done(30, seen, en, gor);
         exp = exp_q.pop_front();
         check("rr_done",       32'(seen), 32'(exp));
         check("rr_grant_excl", 32'(gor),  32'(exp));
         check("rr_run_cycles", 32'(en),   32'd3);
         step();
      end
      bus.req = '0;
      repeat (3) step();

      // Cancel two cycles into RUN; pointer must land on 2.
      pulse_reset();
      set_period(1, 8'd20);
      bus.req = 4'b0010;
      repeat (3) step();
      check("cancel_running", 32'(bus.tmr_enable), 32'd1);
      bus.req = '0;
      step();
      check("cancel_enable", 32'(bus.tmr_enable), 32'd0);
      check("cancel_done",   32'(bus.done),       32'd0);
      check("cancel_grant",  32'(bus.grant),      32'd0);
      check("cancel_busy",   32'(bus.busy),       32'd0);
      bus.req = 4'b0110;
      step();
      check("cancel_rr_ptr", 32'(bus.grant), 32'h4);
      bus.req = '0;
      repeat (3) step();

      // Flag and drop together: done still issued.
      tmr_auto = 1'b0;
      bus.req  = 4'b0010;
      exp_q.push_back(4'b0010);
      repeat (2) step();
      check("flagdrop_running", 32'(bus.tmr_enable), 32'd1);
      bus.req    = '0;
      tmr_manual = 1'b1;
      step();
      exp = exp_q.pop_front();
      check("flagdrop_done", 32'(bus.done), 32'(exp));
      tmr_manual = 1'b0;
      tmr_auto   = 1'b1;
      step();
      check("flagdrop_idle", 32'(bus.busy), 32'd0);

      // Zero period bypasses the timer.
      set_period(2, 8'd0);
      bus.req = 4'b0100;
      exp_q.push_back(4'b0100);
      step();
      exp = exp_q.pop_front();
      check("zero_done",   32'(bus.done),       32'(exp));
      check("zero_grant",  32'(bus.grant),      32'(exp));
      check("zero_load",   32'(bus.tmr_load),   32'd0);
      check("zero_enable", 32'(bus.tmr_enable), 32'd0);
      bus.req = '0;
      step();
      check("zero_done_pulse", 32'(bus.done), 32'd0);

      // Asynchronous reset in the middle of RUN with owner 2.
      set_period(2, 8'd50);
      bus.req = 4'b0100;
      repeat (3) step();
      check("prerst_grant",  32'(bus.grant),      32'h4);
      check("prerst_enable", 32'(bus.tmr_enable), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_enable", 32'(bus.tmr_enable), 32'd0);
      check("midrst_grant",  32'(bus.grant),      32'd0);
      check("midrst_busy",   32'(bus.busy),       32'd0);
      step();
      rst     = 1'b0;
      bus.req = '0;
      step();
      check("postrst_busy",  32'(bus.busy),  32'd0);
      check("postrst_grant", 32'(bus.grant), 32'd0);

`ifdef TIMER_SCHED_WDOG_EN
      // Timer never flags: watchdog aborts after 2*5+4 RUN cycles.
      pulse_reset();
      tmr_auto   = 1'b0;
      tmr_manual = 1'b0;
      set_period(0, 8'd5);
      set_period(1, 8'd5);
      bus.req = 4'b0011;
      step();
      check("wd_grant0", 32'(bus.grant), 32'h1);
      step();
      en  = 0;
      gor = '0;
      for (int i = 0; i < 40; i++) begin
         if (bus.wdog_err) break;
         if (bus.tmr_enable) en++;
         gor |= bus.done;
         step();
      end
      check("wd_err_pulse",  32'(bus.wdog_err),   32'd1);
      check("wd_run_cycles", 32'(en),             32'd14);
      check("wd_no_done",    32'(gor | bus.done), 32'd0);
      step();
      check("wd_err_once",   32'(bus.wdog_err),   32'd0);
      check("wd_next_grant", 32'(bus.grant),      32'h2);
      bus.req  = '0;
      tmr_auto = 1'b1;
      repeat (4) step();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
